// File: rtl/opc_mem_bus_ctrl.sv
// Two-port arbitrating controller for the OPC external 8-bit memory bus.
// The 11-bit address goes out over 8 pins in two latch phases, followed by a data phase that can be stretched.
`timescale 1ns/1ps
module opc_mem_bus_ctrl #(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned FIXED_PRIO  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_rnw,
    input  logic [10:0] p0_addr,
    input  logic [7:0]  p0_wdata,
    output logic        p0_ready,
    input  logic        p1_req,
    input  logic        p1_rnw,
    input  logic [10:0] p1_addr,
    input  logic [7:0]  p1_wdata,
    output logic        p1_ready,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [7:0]  ext_addr,
    output logic        ext_ale_lo,
    output logic        ext_ale_hi,
    output logic        ext_rnw,
    output logic [7:0]  ext_data_o,
    output logic        ext_data_oe,
    input  logic [7:0]  ext_data_i,
    input  logic        ext_wait
);

    generate
        if (WAIT_CYCLES > 15) begin : g_bad_wait
            $error("opc_mem_bus_ctrl: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ALO  = 3'd1,
        S_AHI  = 3'd2,
        S_ACC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic       PRIO_P1   = (FIXED_PRIO != 0);

    state_t      state_q;
    logic [10:0] addr_q;
    logic        rnw_q;
    logic [7:0]  wdata_q;
    logic        gnt_q;
    logic        last_grant_q;
    logic [3:0]  cnt_q;
    logic [7:0]  rdata_q;
    logic        p0_ready_q;
    logic        p1_ready_q;
    logic [7:0]  ext_addr_q;
    logic        ale_lo_q;
    logic        ale_hi_q;
    logic        ext_rnw_q;
    logic [7:0]  ext_data_o_q;
    logic        ext_data_oe_q;
    logic        grant_d;
    logic [10:0] sel_addr_d;

    // Arbitration: port 1 wins when alone, under fixed priority, or when port 0 was served last
    always_comb begin
        grant_d    = 1'b0;
        sel_addr_d = p0_addr;
        if (p1_req && (!p0_req || PRIO_P1 || !last_grant_q)) begin
            grant_d    = 1'b1;
            sel_addr_d = p1_addr;
        end else begin
            grant_d    = 1'b0;
            sel_addr_d = p0_addr;
        end
    end

    // Transaction FSM with all pin outputs registered alongside the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            addr_q        <= 11'h000;
            rnw_q         <= 1'b1;
            wdata_q       <= 8'h00;
            gnt_q         <= 1'b0;
            last_grant_q  <= 1'b1;
            cnt_q         <= 4'd0;
            rdata_q       <= 8'h00;
            p0_ready_q    <= 1'b0;
            p1_ready_q    <= 1'b0;
            ext_addr_q    <= 8'h00;
            ale_lo_q      <= 1'b0;
            ale_hi_q      <= 1'b0;
            ext_rnw_q     <= 1'b1;
            ext_data_o_q  <= 8'h00;
            ext_data_oe_q <= 1'b0;
        end else begin
            p0_ready_q <= 1'b0;
            p1_ready_q <= 1'b0;
            ale_lo_q   <= 1'b0;
            ale_hi_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (p0_req || p1_req) begin
                        gnt_q        <= grant_d;
                        last_grant_q <= grant_d;
                        addr_q       <= sel_addr_d;
                        rnw_q        <= grant_d ? p1_rnw : p0_rnw;
                        wdata_q      <= grant_d ? p1_wdata : p0_wdata;
                        ext_addr_q   <= sel_addr_d[7:0];
                        ale_lo_q     <= 1'b1;
                        state_q      <= S_ALO;
                    end else begin
                        state_q      <= S_IDLE;
                    end
                end
                S_ALO: begin
                    ext_addr_q <= {5'b00000, addr_q[10:8]};
                    ale_hi_q   <= 1'b1;
                    cnt_q      <= WAIT_INIT;
                    state_q    <= S_AHI;
                end
                S_AHI: begin
                    ext_addr_q    <= 8'h00;
                    ext_rnw_q     <= rnw_q;
                    ext_data_oe_q <= !rnw_q;
                    ext_data_o_q  <= rnw_q ? 8'h00 : wdata_q;
                    state_q       <= S_ACC;
                end
                S_ACC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!ext_wait) begin
                        if (rnw_q) begin
                            rdata_q <= ext_data_i;
                        end
                        p0_ready_q    <= !gnt_q;
                        p1_ready_q    <= gnt_q;
                        ext_rnw_q     <= 1'b1;
                        ext_data_oe_q <= 1'b0;
                        ext_data_o_q  <= 8'h00;
                        state_q       <= S_DONE;
                    end else begin
                        state_q <= S_ACC;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    ext_addr_q    <= 8'h00;
                    ext_rnw_q     <= 1'b1;
                    ext_data_oe_q <= 1'b0;
                    ext_data_o_q  <= 8'h00;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign rdata       = rdata_q;
    assign p0_ready    = p0_ready_q;
    assign p1_ready    = p1_ready_q;
    assign ext_addr    = ext_addr_q;
    assign ext_ale_lo  = ale_lo_q;
    assign ext_ale_hi  = ale_hi_q;
    assign ext_rnw     = ext_rnw_q;
    assign ext_data_o  = ext_data_o_q;
    assign ext_data_oe = ext_data_oe_q;

endmodule
